axi_lite_mem_arbiter: RTL and testbench

//   Shares the core's single AXI4-lite master port between the instruction-fetch

---
 rtl/axi_lite_mem_arbiter.sv | 238 +++++++++++++++++++++++
 tb/tb_axi_lite_mem_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_mem_arbiter.sv
// Shares one AXI4-lite master port between instruction fetch (read only) and
// load/store, one transaction in flight, with a bound on how long fetch can starve.
module axi_lite_mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic        gnt_i,
  output logic        gnt_d,
  output logic        rsp_valid,
  output logic        rsp_sel,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] awaddr,
  output logic [2:0]  awprot,
  output logic        wvalid,
  input  logic        wready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  input  logic        bvalid,
  output logic        bready,
  input  logic [1:0]  bresp,
  output logic        arvalid,
  input  logic        arready,
  output logic [31:0] araddr,
  output logic [2:0]  arprot,
  input  logic        rvalid,
  output logic        rready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp
);

  localparam int unsigned SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP
  } state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          sel_q, sel_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic [2:0]    arprot_q, arprot_d;
  logic          arvalid_q, arvalid_d;
  logic          rready_q, rready_d;
  logic          awvalid_q, awvalid_d;
  logic          wvalid_q, wvalid_d;
  logic          bready_q, bready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_sel_q, rsp_sel_d;
  logic [31:0]   rsp_data_q, rsp_data_d;
  logic          rsp_err_q, rsp_err_d;

  logic idle;
  logic pick_i;
  logic aw_done;
  logic w_done;
  logic unused_resp_bits;

  // Data normally wins; fetch is forced once it has been passed over STARVE_MAX times.
  assign idle   = (state_q == IDLE);
  assign pick_i = i_req && (!d_req || (starve_q == STARVE_LIM));
  assign gnt_i  = idle && pick_i;
  assign gnt_d  = idle && d_req && !pick_i;

  assign aw_done = !awvalid_q || awready;
  assign w_done  = !wvalid_q || wready;

  assign unused_resp_bits = &{1'b0, rresp[0], bresp[0]};

  always_comb begin
    // NOTE: every _d defaults to its _q (or to 0 for pulses) before the case,
    // so no path leaves a signal unassigned and no latch is inferred.
    state_d     = state_q;
    starve_d    = starve_q;
    sel_d       = sel_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    arprot_d    = arprot_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    rsp_valid_d = 1'b0;
    rsp_sel_d   = rsp_sel_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      IDLE: begin
        if (gnt_i) begin
          sel_d     = 1'b0;
          addr_d    = i_addr;
          arprot_d  = 3'b101;
          arvalid_d = 1'b1;
          state_d   = RD_ADDR;
          starve_d  = '0;
        end else if (gnt_d) begin
          sel_d  = 1'b1;
          addr_d = d_addr;
          if (d_we) begin
            wdata_d   = d_wdata;
            wstrb_d   = d_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR_REQ;
          end else begin
            arprot_d  = 3'b000;
            arvalid_d = 1'b1;
            state_d   = RD_ADDR;
          end
          if (!i_req) begin
            starve_d = '0;
          end else if (starve_q != STARVE_LIM) begin
            starve_d = starve_q + SW'(1);
          end
        end
      end

      RD_ADDR: begin
        if (arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end

      RD_DATA: begin
        if (rvalid) begin
          rready_d    = 1'b0;
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_sel_d   = sel_q;
          rsp_data_d  = rdata;
          rsp_err_d   = rresp[1];
        end
      end

      WR_REQ: begin
        // AW and W complete independently; B is only accepted once both are done.
        if (awready) awvalid_d = 1'b0;
        if (wready)  wvalid_d  = 1'b0;
        if (aw_done && w_done) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end

      WR_RESP: begin
        if (bvalid) begin
          bready_d    = 1'b0;
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_sel_d   = sel_q;
          rsp_data_d  = 32'h0;
          rsp_err_d   = bresp[1];
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values produced by the combinational block.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      sel_q       <= 1'b0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      wstrb_q     <= 4'h0;
      arprot_q    <= 3'b000;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_sel_q   <= 1'b0;
      rsp_data_q  <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      sel_q       <= sel_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      arprot_q    <= arprot_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_sel_q   <= rsp_sel_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign arvalid   = arvalid_q;
  assign araddr    = addr_q;
  assign arprot    = arprot_q;
  assign rready    = rready_q;
  assign awvalid   = awvalid_q;
  assign awaddr    = addr_q;
  assign awprot    = 3'b000;
  assign wvalid    = wvalid_q;
  assign wdata     = wdata_q;
  assign wstrb     = wstrb_q;
  assign bready    = bready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_sel   = rsp_sel_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_axi_lite_mem_arbiter.sv
// Randomised bench for axi_lite_mem_arbiter: a transaction-level model predicts
// grants, channel phases and responses, plus directed scenarios for the corner cases.
module tb_axi_lite_mem_arbiter;

  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [3:0]  d_wstrb;
  logic        gnt_i, gnt_d, rsp_valid, rsp_sel, rsp_err;
  logic [31:0] rsp_data;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  always #5 clk = ~clk;

  axi_lite_mem_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .gnt_i(gnt_i), .gnt_d(gnt_d),
    .rsp_valid(rsp_valid), .rsp_sel(rsp_sel), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, want, $time);
    end
  endtask

  typedef struct packed {
    logic        sel;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } txn_t;

  // Reference model: one transaction in flight, tracked by which channel phases are done.
  txn_t        cur;
  bit          busy, ar_done, aw_done, w_done;
  int          starve;
  bit          rsp_exp;
  logic        rsp_sel_e, rsp_err_e;
  logic [31:0] rsp_data_e;
  bit          ghist[$];

  // Requester and slave stimulus state.
  bit          drop_i, drop_d, r_taken, b_taken;
  bit          s_rd_pend, s_aw_got, s_w_got;
  bit          inj_i, inj_d, inj_d_we;
  logic [31:0] inj_i_addr, inj_d_addr, inj_d_wdata;
  logic [3:0]  inj_d_wstrb;
  int unsigned p_ireq, p_dreq, p_rdy;
  int          ar_low, aw_low;
  bit          hold_r, fix_rd;
  logic [31:0] fix_rdata;
  logic [1:0]  fix_rresp;

  task automatic model_reset();
    busy = 0; ar_done = 0; aw_done = 0; w_done = 0; starve = 0; rsp_exp = 0;
    drop_i = 0; drop_d = 0; r_taken = 0; b_taken = 0;
    s_rd_pend = 0; s_aw_got = 0; s_w_got = 0; ar_low = 0; aw_low = 0;
  endtask

  task automatic drive();
    if (drop_i)  begin i_req = 1'b0; drop_i = 0; end
    if (drop_d)  begin d_req = 1'b0; drop_d = 0; end
    if (r_taken) begin rvalid = 1'b0; r_taken = 0; end
    if (b_taken) begin bvalid = 1'b0; b_taken = 0; end
    if (inj_i) begin
      i_req = 1'b1; i_addr = inj_i_addr; inj_i = 0;
    end else if (!i_req && $urandom_range(99) < p_ireq) begin
      i_req = 1'b1; i_addr = $urandom & 32'hFFFF_FFFC;
    end
    if (inj_d) begin
      d_req = 1'b1; d_we = inj_d_we; d_addr = inj_d_addr;
      d_wdata = inj_d_wdata; d_wstrb = inj_d_wstrb; inj_d = 0;
    end else if (!d_req && $urandom_range(99) < p_dreq) begin
      d_req = 1'b1; d_we = 1'($urandom_range(1)); d_addr = $urandom & 32'hFFFF_FFFC;
      d_wdata = $urandom; d_wstrb = 4'($urandom_range(15));
    end
    arready = (ar_low == 0) && ($urandom_range(99) < p_rdy);
    awready = (aw_low == 0) && ($urandom_range(99) < p_rdy);
    wready  = ($urandom_range(99) < p_rdy);
    if (s_rd_pend && !rvalid && !hold_r && $urandom_range(99) < p_rdy) begin
      rvalid = 1'b1;
      rdata  = fix_rd ? fix_rdata : $urandom;
      rresp  = fix_rd ? fix_rresp : 2'($urandom_range(3));
    end
    if (s_aw_got && s_w_got && !bvalid && $urandom_range(99) < p_rdy) begin
      bvalid = 1'b1;
      bresp  = fix_rd ? fix_rresp : 2'($urandom_range(3));
    end
  endtask

  task automatic observe();
    logic exp_gi, exp_gd;
    check("rsp_valid", rsp_valid, rsp_exp);
    if (rsp_exp) begin
      check("rsp_sel", rsp_sel, rsp_sel_e);
      check("rsp_data", rsp_data, rsp_data_e);
      check("rsp_err", rsp_err, rsp_err_e);
      rsp_exp = 0;
    end
    check("arvalid", arvalid, busy && !cur.we && !ar_done);
    check("rready", rready, busy && !cur.we && ar_done);
    check("awvalid", awvalid, busy && cur.we && !aw_done);
    check("wvalid", wvalid, busy && cur.we && !w_done);
    check("bready", bready, busy && cur.we && aw_done && w_done);
    if (arvalid) begin
      check("araddr", araddr, cur.addr);
      check("arprot", arprot, cur.sel ? 3'b000 : 3'b101);
    end
    if (awvalid) begin
      check("awaddr", awaddr, cur.addr);
      check("awprot", awprot, 3'b000);
    end
    if (wvalid) begin
      check("wdata", wdata, cur.wdata);
      check("wstrb", wstrb, cur.wstrb);
    end
    exp_gi = !busy && i_req && (!d_req || starve == STARVE_MAX);
    exp_gd = !busy && d_req && !exp_gi;
    check("gnt_i", gnt_i, exp_gi);
    check("gnt_d", gnt_d, exp_gd);

    // Handshakes that the coming clock edge will complete.
    if (arvalid && arready) begin ar_done = 1; s_rd_pend = 1; end
    if (rvalid && rready) begin
      r_taken = 1; s_rd_pend = 0; busy = 0; rsp_exp = 1;
      rsp_sel_e = cur.sel; rsp_data_e = rdata; rsp_err_e = rresp[1];
    end
    if (awvalid && awready) begin aw_done = 1; s_aw_got = 1; end
    if (wvalid && wready)   begin w_done = 1; s_w_got = 1; end
    if (bvalid && bready) begin
      b_taken = 1; s_aw_got = 0; s_w_got = 0; busy = 0; rsp_exp = 1;
      rsp_sel_e = cur.sel; rsp_data_e = 32'h0; rsp_err_e = bresp[1];
    end
    if (arvalid && ar_low > 0) ar_low--;
    if (awvalid && aw_low > 0) aw_low--;

    if (exp_gi) begin
      cur = '{sel: 1'b0, we: 1'b0, addr: i_addr, wdata: 32'h0, wstrb: 4'h0};
      busy = 1; ar_done = 0; aw_done = 0; w_done = 0;
      starve = 0; drop_i = 1; ghist.push_back(1'b1);
    end else if (exp_gd) begin
      cur = '{sel: 1'b1, we: d_we, addr: d_addr, wdata: d_wdata, wstrb: d_wstrb};
      busy = 1; ar_done = 0; aw_done = 0; w_done = 0;
      starve = !i_req ? 0 : (starve < STARVE_MAX ? starve + 1 : starve);
      drop_d = 1; ghist.push_back(1'b0);
    end
  endtask

  task automatic step();
    @(negedge clk);
    drive();
    #1;
    observe();
  endtask

  task automatic drain();
    p_ireq = 0; p_dreq = 0; p_rdy = 100; hold_r = 0; ar_low = 0; aw_low = 0;
    for (int k = 0; k < 60 && (busy || i_req || d_req || rsp_exp); k++) step();
    check("drain_idle", {busy, i_req, d_req}, 3'b000);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ctl"}, {gnt_i, gnt_d, rsp_valid, arvalid, rready, awvalid, wvalid, bready}, 8'h00);
    check({tag, "_araddr"}, araddr, 32'h0);
    check({tag, "_awaddr"}, awaddr, 32'h0);
    check({tag, "_wdata"}, wdata, 32'h0);
    check({tag, "_misc"}, {wstrb, arprot, awprot, rsp_sel, rsp_err}, 15'h0);
    check({tag, "_rsp_data"}, rsp_data, 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int pat[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    reset = 1'b1;
    i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_wstrb = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    inj_i = 0; inj_d = 0; hold_r = 0; fix_rd = 0; p_ireq = 0; p_dreq = 0; p_rdy = 100;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_quiet("reset");
    reset = 1'b0;

    // Fetch from 0x100 on a zero-wait slave.
    fix_rd = 1; fix_rdata = 32'h0000_0013; fix_rresp = 2'b00;
    inj_i = 1; inj_i_addr = 32'h100;
    step(); check("t1_gnt_i", gnt_i, 1'b1);
    step(); check("t1_araddr", araddr, 32'h100); check("t1_arprot", arprot, 3'b101);
    step();
    step(); check("t1_rsp_valid", rsp_valid, 1'b1); check("t1_rsp_sel", rsp_sel, 1'b0);
    check("t1_rsp_data", rsp_data, 32'h13);
    drain();

    // Load returning an error; a fetch is granted in the same cycle as the response.
    fix_rdata = 32'hBAD0_BAD0; fix_rresp = 2'b10;
    inj_d = 1; inj_d_we = 0; inj_d_addr = 32'h40; inj_d_wdata = 0; inj_d_wstrb = 0;
    step(); check("t4_gnt_d", gnt_d, 1'b1);
    step();
    step();
    inj_i = 1; inj_i_addr = 32'h80;
    step(); check("t4_rsp_err", rsp_err, 1'b1); check("t4_rsp_data", rsp_data, 32'hBAD0_BAD0);
    check("t4_next_gnt_i", gnt_i, 1'b1);
    drain();

    // Store with AW stalled two cycles while W completes at once.
    fix_rresp = 2'b00; aw_low = 2;
    inj_d = 1; inj_d_we = 1; inj_d_addr = 32'h2000; inj_d_wdata = 32'hDEAD_BEEF; inj_d_wstrb = 4'b0011;
    step(); check("t2_gnt_d", gnt_d, 1'b1);
    step(); check("t2_aw_w_valid", {awvalid, wvalid}, 2'b11); check("t2_wstrb", wstrb, 4'b0011);
    step(); check("t2_wvalid_drop", wvalid, 1'b0); check("t2_awvalid_hold", awvalid, 1'b1);
    check("t2_awaddr", awaddr, 32'h2000); check("t2_bready_early", bready, 1'b0);
    step(); check("t2_bready_wait", bready, 1'b0);
    step(); check("t2_bready", bready, 1'b1);
    step(); check("t2_rsp_valid", rsp_valid, 1'b1); check("t2_rsp_sel", rsp_sel, 1'b1);
    check("t2_rsp_err", rsp_err, 1'b0); check("t2_rsp_data", rsp_data, 32'h0);
    drain();
    fix_rd = 0;

    // Reset while waiting for read data.
    hold_r = 1; inj_i = 1; inj_i_addr = 32'h500;
    step(); step();
    step(); check("t5_rready", rready, 1'b1);
    reset = 1'b1; i_req = 0; d_req = 0; rvalid = 0; bvalid = 0;
    @(negedge clk);
    #1;
    check_quiet("t5");
    reset = 1'b0; hold_r = 0;
    model_reset();
    step(); check("t5_no_rsp", rsp_valid, 1'b0);
    inj_i = 1; inj_i_addr = 32'h600;
    step(); check("t5_gnt_after_reset", gnt_i, 1'b1);
    drain();

    // arready held low ten cycles with a load waiting behind the fetch.
    ar_low = 10; inj_i = 1; inj_i_addr = 32'h300;
    step(); check("t6_gnt_i", gnt_i, 1'b1);
    inj_d = 1; inj_d_we = 0; inj_d_addr = 32'h400; inj_d_wdata = 0; inj_d_wstrb = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      check("t6_arvalid", arvalid, 1'b1);
      check("t6_araddr", araddr, 32'h300);
      check("t6_no_gnt_d", gnt_d, 1'b0);
    end
    step(); step();
    step(); check("t6_rsp_valid", rsp_valid, 1'b1); check("t6_gnt_d", gnt_d, 1'b1);
    drain();

    // Both requesters always asking: D,D,D,D,I repeating.
    ghist.delete();
    p_ireq = 100; p_dreq = 100; p_rdy = 100;
    repeat (45) step();
    check("t3_ngrants", ghist.size() >= 10, 1'b1);
    for (int k = 0; k < 10; k++) check("t3_grant_seq", ghist[k], pat[k]);
    drain();

    // Random traffic, light then heavy.
    p_ireq = 30; p_dreq = 40; p_rdy = 60;
    repeat (3000) step();
    p_ireq = 90; p_dreq = 90; p_rdy = 85;
    repeat (1000) step();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
